// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Loads the CPU instruction memory from a byte stream. Bytes arrive over a
// valid/ready handshake and are paired big-endian into 16-bit words. Each word
// is written with a one-cycle strobe to consecutive addresses, starting at
// BASE_ADDR and wrapping modulo 256. A trailing 16-bit word is compared with
// the running sum of all written words (mod 2^16).
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       begin a load (honoured only in IDLE or DONE)
//   length      number of words to load, 0..256 (sampled with start)
//   byte_in     stream byte
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts a byte this cycle
//   mem_addr    instruction-memory write address (registered)
//   mem_data    instruction-memory write data (registered)
//   mem_we      write strobe, one cycle per word
//   busy        load in progress (accepted start until DONE)
//   done        level, high in DONE
//   err         valid while done: bad length or checksum mismatch
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  length,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_HI,
    S_RX_LO,
    S_WRITE,
    S_CK_HI,
    S_CK_LO,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [8:0]  len_q;
  logic [8:0]  count_q;
  logic [15:0] acc_q;
  logic [7:0]  hi_q;       // high byte of the word (or checksum) being assembled
  logic        ready_q;
  logic        we_q;
  logic [7:0]  addr_q;
  logic [15:0] data_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic        xfer;
  logic [8:0]  count_d;

  // ready_q is high exactly in the four receive states, so a transfer is
  // simply a valid byte while ready is shown.
  assign xfer    = byte_valid && ready_q;
  assign count_d = count_q + 9'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q   <= length;
            count_q <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            if (length > 9'd256) begin
              // Rejected load: report immediately, nothing is written.
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b0;
            end else begin
              // An empty program goes straight to the checksum word.
              state_q <= (length == 9'd0) ? S_CK_HI : S_RX_HI;
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
              ready_q <= 1'b1;
            end
          end
        end

        S_RX_HI: begin
          if (xfer) begin
            hi_q    <= byte_in;
            state_q <= S_RX_LO;
          end
        end

        S_RX_LO: begin
          if (xfer) begin
            // Address and data are registered here so they are stable for
            // the whole strobe cycle that follows.
            addr_q  <= BASE_ADDR + count_q[7:0];
            data_q  <= {hi_q, byte_in};
            we_q    <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_WRITE;
          end
        end

        S_WRITE: begin
          acc_q   <= acc_q + data_q;
          count_q <= count_d;
          ready_q <= 1'b1;
          state_q <= (count_d == len_q) ? S_CK_HI : S_RX_HI;
        end

        S_CK_HI: begin
          if (xfer) begin
            hi_q    <= byte_in;
            state_q <= S_CK_LO;
          end
        end

        S_CK_LO: begin
          if (xfer) begin
            err_q   <= ({hi_q, byte_in} != acc_q);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= S_DONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = ready_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Three loaders with different BASE_ADDR values (00, FE, 10) share one
// stimulus stream. Expected words are pushed to a scoreboard queue as they are
// sent; captured writes from each instance are popped against it once the load
// completes.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int ND = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  length;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        byte_ready_w [ND];
  logic [7:0]  mem_addr_w   [ND];
  logic [15:0] mem_data_w   [ND];
  logic        mem_we_w     [ND];
  logic        busy_w       [ND];
  logic        done_w       [ND];
  logic        err_w        [ND];

  logic [7:0]  bases [ND];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q [$];      // scoreboard of expected write data, in order
  logic [23:0] cap0 [$];       // captured {addr, data} per instance
  logic [23:0] cap1 [$];
  logic [23:0] cap2 [$];
  logic [15:0] words [256];

  prog_loader #(.BASE_ADDR(8'h00)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready_w[0]),
    .mem_addr(mem_addr_w[0]), .mem_data(mem_data_w[0]), .mem_we(mem_we_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
  );

  prog_loader #(.BASE_ADDR(8'hFE)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready_w[1]),
    .mem_addr(mem_addr_w[1]), .mem_data(mem_data_w[1]), .mem_we(mem_we_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
  );

  prog_loader #(.BASE_ADDR(8'h10)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready_w[2]),
    .mem_addr(mem_addr_w[2]), .mem_data(mem_data_w[2]), .mem_we(mem_we_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .err(err_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every strobe cycle; a strobe lasting two cycles shows up as a
  // duplicate entry and is caught by the write-count check.
  always @(negedge clk) if (mem_we_w[0]) cap0.push_back({mem_addr_w[0], mem_data_w[0]});
  always @(negedge clk) if (mem_we_w[1]) cap1.push_back({mem_addr_w[1], mem_data_w[1]});
  always @(negedge clk) if (mem_we_w[2]) cap2.push_back({mem_addr_w[2], mem_data_w[2]});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic int cap_size(input int d);
    case (d)
      0:       return cap0.size();
      1:       return cap1.size();
      default: return cap2.size();
    endcase
  endfunction

  function automatic logic [23:0] cap_at(input int d, input int j);
    case (d)
      0:       return cap0[j];
      1:       return cap1[j];
      default: return cap2[j];
    endcase
  endfunction

  task automatic check_ctrl(input string tag, input logic rdy, input logic bsy,
                            input logic dn, input logic er);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s_ready%0d", tag, d), {31'b0, byte_ready_w[d]}, {31'b0, rdy});
      check($sformatf("%s_busy%0d", tag, d),  {31'b0, busy_w[d]},       {31'b0, bsy});
      check($sformatf("%s_done%0d", tag, d),  {31'b0, done_w[d]},       {31'b0, dn});
      check($sformatf("%s_err%0d", tag, d),   {31'b0, err_w[d]},        {31'b0, er});
    end
  endtask

  task automatic check_reset(input string tag);
    check_ctrl(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s_we%0d", tag, d),   {31'b0, mem_we_w[d]},   32'd0);
      check($sformatf("%s_addr%0d", tag, d), {24'b0, mem_addr_w[d]}, {24'b0, bases[d]});
      check($sformatf("%s_data%0d", tag, d), {16'b0, mem_data_w[d]}, 32'd0);
    end
  endtask

  // Pop the scoreboard and compare against writes captured since the snapshot.
  task automatic check_writes(input string tag, input int snap [ND]);
    int n;
    logic [15:0] e;
    logic [23:0] c;
    logic [7:0]  a;
    n = exp_q.size();
    for (int d = 0; d < ND; d++)
      check($sformatf("%s_nwrites%0d", tag, d), cap_size(d) - snap[d], n);
    for (int j = 0; j < n; j++) begin
      e = exp_q.pop_front();
      for (int d = 0; d < ND; d++) begin
        if (snap[d] + j < cap_size(d)) begin
          c = cap_at(d, snap[d] + j);
          a = bases[d] + j[7:0];
          check($sformatf("%s_w%0d_addr%0d", tag, j, d), {24'b0, c[23:16]}, {24'b0, a});
          check($sformatf("%s_w%0d_data%0d", tag, j, d), {16'b0, c[15:0]}, {16'b0, e});
        end
      end
    end
  endtask

  task automatic take_snap(output int snap [ND]);
    for (int d = 0; d < ND; d++) snap[d] = cap_size(d);
  endtask

  task automatic do_start(input logic [8:0] len);
    start  = 1'b1;
    length = len;
    @(negedge clk);
    start  = 1'b0;
    length = 9'($urandom);
  endtask

  // Present one byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int budget;
    if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    budget     = 0;
    while (!byte_ready_w[0] && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) check("byte_timeout", {31'b0, byte_ready_w[0]}, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  task automatic send_word(input logic [15:0] w, input bit stall);
    send_byte(w[15:8], stall);
    send_byte(w[7:0], stall);
  endtask

  task automatic run_load(input string tag, input logic [8:0] len,
                          input bit bad_ck, input bit stall);
    int snap [ND];
    int budget;
    logic [15:0] acc;
    acc = '0;
    take_snap(snap);
    do_start(len);
    check_ctrl({tag, "_start"}, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < int'(len); k++) begin
      exp_q.push_back(words[k]);
      acc = acc + words[k];
      send_word(words[k], stall);
      if (stall) begin
        // A start while busy must be ignored.
        start  = 1'b1;
        length = 9'h101;
        @(negedge clk);
        start  = 1'b0;
      end
    end
    send_word(bad_ck ? acc + 16'd1 : acc, stall);
    budget = 0;
    while (!done_w[0] && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check_ctrl({tag, "_end"}, 1'b0, 1'b0, 1'b1, bad_ck);
    check_writes(tag, snap);
  endtask

  initial begin
    int snap [ND];
    bases[0] = 8'h00;
    bases[1] = 8'hFE;
    bases[2] = 8'h10;
    reset      = 1'b1;
    start      = 1'b0;
    length     = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset = 1'b0;
    @(negedge clk);

    // Normal load of four words; checksum F316.
    words[0] = 16'h6100;
    words[1] = 16'h4001;
    words[2] = 16'h4002;
    words[3] = 16'h1213;
    run_load("normal", 9'd4, 1'b0, 1'b0);

    // Same stream with checksum F317.
    run_load("badck", 9'd4, 1'b1, 1'b0);

    // Back-to-back from DONE with err=1: err clears and addressing restarts.
    run_load("b2b", 9'd4, 1'b0, 1'b0);

    // Empty program, checksum 0000.
    run_load("len0", 9'd0, 1'b0, 1'b0);

    // Illegal length: rejected one cycle after start, never ready.
    take_snap(snap);
    byte_valid = 1'b1;
    do_start(9'h101);
    check_ctrl("badlen", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("badlen_ready_c%0d", i), {31'b0, byte_ready_w[0]}, 32'd0);
    end
    byte_valid = 1'b0;
    check_writes("badlen", snap);

    // Random stalls, start pulses mid-load, FE instance wraps FE,FF,00.
    words[0] = 16'hA55A;
    words[1] = 16'h0F0F;
    words[2] = 16'h1234;
    run_load("stall", 9'd3, 1'b0, 1'b1);

    // Reset after the second word's write cycle.
    take_snap(snap);
    do_start(9'd4);
    words[0] = 16'h6100;
    words[1] = 16'h4001;
    exp_q.push_back(words[0]);
    exp_q.push_back(words[1]);
    send_word(words[0], 1'b0);
    send_word(words[1], 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset("midreset");
    reset = 1'b0;
    @(negedge clk);
    check_writes("midreset", snap);

    words[0] = 16'hABCD;
    run_load("post_reset", 9'd1, 1'b0, 1'b0);

    // Full 256-word program: the base-10 instance ends at 0F.
    for (int k = 0; k < 256; k++) words[k] = 16'($urandom);
    run_load("full", 9'd256, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
